// File: rtl/core2wishbone_bridge.sv
`default_nettype none
// ============================================================================
// Module   : core2wishbone_bridge
// Purpose  : Bridges the Aquila device I/O port to a single-beat Wishbone B4
//            pipelined master. Each core request is registered and driven as
//            one Wishbone cycle that honours stall. The cycle ends on ack, on
//            err, or on a watchdog timeout. Registered read data is returned
//            with a one-cycle ready pulse.
// Ports    : clk_i, rst_n_i          - clock, asynchronous active-low reset
//            S_DEVICE_*_i            - core request (strobe/addr/rw/be/data)
//            S_DEVICE_data_ready_o   - one-cycle completion pulse
//            S_DEVICE_data_o/err_o   - read data / error, valid with ready
//            busy_o                  - a bus cycle is in flight
//            wb_*_o                  - registered Wishbone master outputs
//            wb_stall_i/ack_i/err_i  - Wishbone slave responses
//            wb_dat_i                - Wishbone read data
// Revision : 1.0 - initial release
// ============================================================================
module core2wishbone_bridge #(
    parameter int XLEN     = 32,
    parameter int AW       = 8,
    parameter int ADDR_LSB = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              S_DEVICE_strobe_i,
    input  logic [XLEN-1:0]   S_DEVICE_addr_i,
    input  logic              S_DEVICE_rw_i,
    input  logic [XLEN/8-1:0] S_DEVICE_byte_enable_i,
    input  logic [XLEN-1:0]   S_DEVICE_data_i,
    output logic              S_DEVICE_data_ready_o,
    output logic [XLEN-1:0]   S_DEVICE_data_o,
    output logic              S_DEVICE_err_o,
    output logic              busy_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_adr_o,
    output logic [XLEN-1:0]   wb_dat_o,
    output logic [XLEN/8-1:0] wb_sel_o,
    input  logic              wb_stall_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic [XLEN-1:0]   wb_dat_i
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_req  = 2'd1;
    localparam logic [1:0] c_wait = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    localparam logic [CW-1:0] c_cnt_max  = CW'(TIMEOUT);
    // The abort decision is taken one cycle before the counter would reach
    // TIMEOUT, so cyc is high for at most TIMEOUT cycles.
    localparam logic [CW-1:0] c_cnt_last = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_cyc;
    logic              r_stb;
    logic              r_we;
    logic [AW-1:0]     r_adr;
    logic [XLEN-1:0]   r_dat;
    logic [XLEN/8-1:0] r_sel;
    logic [XLEN-1:0]   r_rdata;
    logic              r_err;

    logic              w_active;
    logic              w_expire;
    logic              w_unused_addr;

    assign w_active = (r_state == c_req) || (r_state == c_wait);

    // Only the word-address slice of the byte address reaches the bus.
    assign w_unused_addr = ^S_DEVICE_addr_i;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            assign w_expire = (r_cnt == c_cnt_last);
        end else begin : g_no_wdog
            assign w_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_idle, c_done: begin
                    if (S_DEVICE_strobe_i) begin
                        r_state <= c_req;
                        r_cnt   <= '0;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= S_DEVICE_rw_i;
                        r_adr   <= S_DEVICE_addr_i[ADDR_LSB+AW-1:ADDR_LSB];
                        r_dat   <= S_DEVICE_data_i;
                        r_sel   <= S_DEVICE_byte_enable_i;
                    end else begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    // A slave response wins over a watchdog expiry in the
                    // same cycle; err wins over a simultaneous ack.
                    if (wb_ack_i || wb_err_i) begin
                        r_state <= c_done;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_err   <= wb_err_i;
                        r_rdata <= (!wb_err_i && !r_we) ? wb_dat_i : '0;
                    end else if (w_expire) begin
                        r_state <= c_done;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else if ((r_state == c_req) && !wb_stall_i) begin
                        r_state <= c_wait;
                        r_stb   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign wb_cyc_o              = r_cyc;
    assign wb_stb_o              = r_stb;
    assign wb_we_o               = r_we;
    assign wb_adr_o              = r_adr;
    assign wb_dat_o              = r_dat;
    assign wb_sel_o              = r_sel;
    assign S_DEVICE_data_o       = r_rdata;
    assign S_DEVICE_err_o        = r_err;
    assign S_DEVICE_data_ready_o = (r_state == c_done);
    assign busy_o                = w_active;

endmodule
`default_nettype wire
